m_stage_dcache: RTL and testbench

- Memory-stage data cache controller, directly downstream of the EX/M pipeline register; consumes its M_* outputs.
- Direct-mapped, write-through, no-write-allocate cache with 4-word lines; refills from main memory in bursts.
- Returns load data (lw/lh) to the M/WB path.
- Raises M_stall so the hazard unit drops EX_MWrite and freezes the upstream stages.

---
 rtl/m_stage_dcache_pkg.sv | 26 ++
 rtl/m_stage_dcache_if.sv | 29 ++
 rtl/m_stage_dcache_array.sv | 35 +++
 rtl/m_stage_dcache.sv | 128 ++++++++++++
 tb/tb_m_stage_dcache.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/m_stage_dcache_pkg.sv
// m_stage_dcache_pkg: shared sizes, address field positions, FSM states and helpers for the M-stage data cache.
package m_stage_dcache_pkg;
  localparam int DATA_SIZE      = 32;
  localparam int ADDR_SIZE      = 18;
  localparam int LINES          = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int CNT_SIZE       = 16;
  localparam int WOFF_LSB       = 2;
  localparam int WOFF_MSB       = 3;
  localparam int IDX_LSB        = 4;
  localparam int IDX_MSB        = 7;
  localparam int TAG_LSB        = 8;
  localparam int TAG_MSB        = 17;
  localparam int WOFF_W         = WOFF_MSB - WOFF_LSB + 1;
  localparam int IDX_W          = IDX_MSB - IDX_LSB + 1;
  localparam int TAG_W          = TAG_MSB - TAG_LSB + 1;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;
  function automatic logic [CNT_SIZE-1:0] sat_inc(input logic [CNT_SIZE-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/m_stage_dcache_if.sv
// m_stage_dcache_if: M-stage access signals, memory bus and performance counters of the data cache.
interface m_stage_dcache_if;
  import m_stage_dcache_pkg::*;
  logic                 M_MemRead;
  logic                 M_MemWrite;
  logic                 M_m_dt_lh;
  logic                 M_m_dt_sh;
  logic [DATA_SIZE-1:0] M_ALU_result;
  logic [DATA_SIZE-1:0] M_Rt_data;
  logic [DATA_SIZE-1:0] M_DM_data;
  logic                 M_stall;
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [3:0]           mem_be;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 mem_ready;
  logic [CNT_SIZE-1:0]  hit_cnt;
  logic [CNT_SIZE-1:0]  miss_cnt;
  modport slave (
    input  M_MemRead, M_MemWrite, M_m_dt_lh, M_m_dt_sh, M_ALU_result, M_Rt_data, mem_rdata, mem_ready,
    output M_DM_data, M_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, hit_cnt, miss_cnt
  );
  modport master (
    output M_MemRead, M_MemWrite, M_m_dt_lh, M_m_dt_sh, M_ALU_result, M_Rt_data, mem_rdata, mem_ready,
    input  M_DM_data, M_stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be, hit_cnt, miss_cnt
  );
endinterface

// File: rtl/m_stage_dcache_array.sv
// dcache_array: valid/tag/data storage with a combinational read port and byte-enabled word writes.
module dcache_array
  import m_stage_dcache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     i_idx,
  input  logic [WOFF_W-1:0]    i_woff,
  output logic                 o_valid,
  output logic [TAG_W-1:0]     o_tag,
  output logic [DATA_SIZE-1:0] o_rdata,
  input  logic                 i_we,
  input  logic [3:0]           i_be,
  input  logic [DATA_SIZE-1:0] i_wdata,
  input  logic                 i_fill,
  input  logic [TAG_W-1:0]     i_fill_tag
);
  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [DATA_SIZE-1:0] r_data [LINES][WORDS_PER_LINE];
  assign o_valid = r_valid[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_rdata = r_data[i_idx][i_woff];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_valid <= '0;
    else if (i_fill) r_valid[i_idx] <= 1'b1;
  end
  // tags and data are deliberately not reset; valid bits alone qualify them
  always_ff @(posedge clk) begin
    if (i_fill) r_tag[i_idx] <= i_fill_tag;
    if (i_we)
      for (int b = 0; b < 4; b++)
        if (i_be[b]) r_data[i_idx][i_woff][8*b +: 8] <= i_wdata[8*b +: 8];
  end
endmodule

// File: rtl/m_stage_dcache.sv
// m_stage_dcache: direct-mapped write-through, no-write-allocate M-stage data cache controller.
// Loads hit combinationally; misses refill a 4-word line in a burst, stores go straight to memory.
module m_stage_dcache
  import m_stage_dcache_pkg::*;
(
  input logic             clk,
  input logic             rst,
  m_stage_dcache_if.slave bus
);
  state_t               r_state;
  logic [WOFF_W-1:0]    r_cnt;
  logic [CNT_SIZE-1:0]  r_hit_cnt;
  logic [CNT_SIZE-1:0]  r_miss_cnt;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [ADDR_SIZE-1:0] r_mem_addr;
  logic [DATA_SIZE-1:0] r_mem_wdata;
  logic [3:0]           r_mem_be;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [IDX_W-1:0]     w_idx;
  logic [WOFF_W-1:0]    w_woff;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_valid;
  logic [TAG_W-1:0]     w_tag_arr;
  logic [DATA_SIZE-1:0] w_word;
  logic                 w_hit;
  logic                 w_idle;
  logic                 w_rd;
  logic                 w_refill_beat;
  logic                 w_we;
  logic                 w_fill;
  logic [15:0]          w_half;
  logic [DATA_SIZE-1:0] w_load;
  logic [3:0]           w_be_st;
  logic [DATA_SIZE-1:0] w_wdata_st;
  logic                 w_unused;
  assign w_unused = ^bus.M_ALU_result[DATA_SIZE-1:ADDR_SIZE];
  assign w_addr   = bus.M_ALU_result[ADDR_SIZE-1:0];
  assign w_idx    = w_addr[IDX_MSB:IDX_LSB];
  assign w_woff   = w_addr[WOFF_MSB:WOFF_LSB];
  assign w_tag    = w_addr[TAG_MSB:TAG_LSB];
  assign w_idle   = r_state == IDLE;
  assign w_rd     = bus.M_MemRead && !bus.M_MemWrite;
  assign w_hit    = w_valid && w_tag_arr == w_tag;
  assign w_refill_beat = r_state == REFILL && bus.mem_ready;
  assign w_we     = w_refill_beat || (r_state == WRITE && bus.mem_ready && w_hit);
  assign w_fill   = w_refill_beat && r_cnt == 2'd3;
  dcache_array u_array (
    .clk       (clk),
    .rst       (rst),
    .i_idx     (w_idx),
    .i_woff    (r_state == REFILL ? r_cnt : w_woff),
    .o_valid   (w_valid),
    .o_tag     (w_tag_arr),
    .o_rdata   (w_word),
    .i_we      (w_we),
    .i_be      (r_state == REFILL ? 4'b1111 : r_mem_be),
    .i_wdata   (r_state == REFILL ? bus.mem_rdata : r_mem_wdata),
    .i_fill    (w_fill),
    .i_fill_tag(w_tag)
  );
  assign w_half     = w_addr[1] ? w_word[31:16] : w_word[15:0];
  assign w_load     = bus.M_m_dt_lh ? {{16{w_half[15]}}, w_half} : w_word;
  assign w_be_st    = bus.M_m_dt_sh ? (w_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign w_wdata_st = bus.M_m_dt_sh ? {2{bus.M_Rt_data[15:0]}} : bus.M_Rt_data;
  assign bus.M_DM_data = (w_idle && w_rd && w_hit) ? w_load : '0;
  // the stall must rise in the same cycle a miss or store is seen, so it cannot be registered
  assign bus.M_stall = !rst && (r_state == REFILL || r_state == WRITE ||
                                (w_idle && (bus.M_MemWrite || (w_rd && !w_hit))));
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_be    = r_mem_be;
  assign bus.hit_cnt   = r_hit_cnt;
  assign bus.miss_cnt  = r_miss_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.M_MemWrite) begin
            r_state     <= WRITE;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {w_addr[ADDR_SIZE-1:WOFF_LSB], 2'b00};
            r_mem_wdata <= w_wdata_st;
            r_mem_be    <= w_be_st;
          end else if (bus.M_MemRead && !w_hit) begin
            r_state    <= REFILL;
            r_cnt      <= '0;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {w_tag, w_idx, {WOFF_W{1'b0}}, 2'b00};
            r_miss_cnt <= sat_inc(r_miss_cnt);
          end else if (bus.M_MemRead) r_hit_cnt <= sat_inc(r_hit_cnt);
        end
        REFILL: begin
          if (bus.mem_ready) begin
            r_cnt                         <= r_cnt + 1'b1;
            r_mem_addr[WOFF_MSB:WOFF_LSB] <= r_cnt + 1'b1;
            if (r_cnt == 2'd3) begin
              r_state   <= IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        WRITE: begin
          if (bus.mem_ready) begin
            r_state   <= DONE;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
          end
        end
        DONE: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_m_stage_dcache.sv
// tb_m_stage_dcache: directed checks of refill, hits, lh alignment, stores, tag conflicts and async reset.
module tb_m_stage_dcache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  m_stage_dcache_if bus ();
  m_stage_dcache dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] memf(input logic [17:0] a);
    return (a == 18'h44) ? 32'hFFFF8001 : (32'hC0DE0000 ^ {14'd0, a});
  endfunction
  // caller has set the load inputs just after a negedge; returns in the first non-stalled cycle
  task automatic serve_read(input logic [17:0] base);
    int stalls = 0;
    int beats  = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.M_stall) break;
      stalls++;
      if (bus.mem_req) begin
        check("rd_we", {31'd0, bus.mem_we}, 32'd0);
        check("rd_addr", {14'd0, bus.mem_addr}, {14'd0, base} + 32'(beats * 4));
        bus.mem_rdata = memf(bus.mem_addr);
        bus.mem_ready = 1'b1;
        beats++;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
    check("rd_beats", beats, 4);
    check("rd_stalls", stalls, 5);
  endtask
  // caller has set the store inputs; returns in the DONE cycle with the store withdrawn
  task automatic serve_write(input logic [17:0] a, input logic [3:0] be, input logic [31:0] wd, input int waits);
    int stalls = 0;
    int reqs   = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!bus.M_stall) break;
      stalls++;
      if (bus.mem_req) begin
        reqs++;
        check("wr_we", {31'd0, bus.mem_we}, 32'd1);
        check("wr_addr", {14'd0, bus.mem_addr}, {14'd0, a});
        check("wr_be", {28'd0, bus.mem_be}, {28'd0, be});
        check("wr_data", bus.mem_wdata, wd);
        bus.mem_ready = reqs > waits;
      end
      @(negedge clk);
      bus.mem_ready = 1'b0;
    end
    check("wr_reqs", reqs, waits + 1);
    check("wr_stalls", stalls, waits + 2);
    check("done_req", {31'd0, bus.mem_req}, 32'd0);
    bus.M_MemWrite = 1'b0;
    bus.M_m_dt_sh  = 1'b0;
  endtask
  initial begin
    bus.M_MemRead = 0; bus.M_MemWrite = 0; bus.M_m_dt_lh = 0; bus.M_m_dt_sh = 0;
    bus.M_ALU_result = '0; bus.M_Rt_data = '0; bus.mem_rdata = '0; bus.mem_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_stall", {31'd0, bus.M_stall}, 32'd0);
    check("rst_addr", {14'd0, bus.mem_addr}, 32'd0);
    check("rst_dm", bus.M_DM_data, 32'd0);
    check("rst_hit", {16'd0, bus.hit_cnt}, 32'd0);
    check("rst_miss", {16'd0, bus.miss_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.M_MemRead = 1; bus.M_ALU_result = 32'h40;
    serve_read(18'h40);
    check("lw40_dm", bus.M_DM_data, memf(18'h40));
    check("lw40_miss", {16'd0, bus.miss_cnt}, 32'd1);
    @(negedge clk);
    bus.M_m_dt_lh = 1; bus.M_ALU_result = 32'h44;
    #1;
    check("hit_cnt1", {16'd0, bus.hit_cnt}, 32'd1);
    check("lh44", bus.M_DM_data, 32'hFFFF8001);
    check("lh44_stall", {31'd0, bus.M_stall}, 32'd0);
    @(negedge clk);
    bus.M_ALU_result = 32'h46;
    #1;
    check("lh46", bus.M_DM_data, 32'hFFFFFFFF);
    @(negedge clk);
    bus.M_MemRead = 0; bus.M_m_dt_lh = 0;
    bus.M_MemWrite = 1; bus.M_m_dt_sh = 1; bus.M_ALU_result = 32'h46; bus.M_Rt_data = 32'h0000ABCD;
    serve_write(18'h44, 4'b1100, 32'hABCDABCD, 0);
    @(negedge clk);
    bus.M_MemRead = 1; bus.M_ALU_result = 32'h44;
    #1;
    check("lw44_merge", bus.M_DM_data, 32'hABCD8001);
    check("lw44_stall", {31'd0, bus.M_stall}, 32'd0);
    check("hit_cnt3", {16'd0, bus.hit_cnt}, 32'd3);
    @(negedge clk);
    bus.M_MemRead = 0; bus.M_MemWrite = 1; bus.M_ALU_result = 32'h1F000; bus.M_Rt_data = 32'h12345678;
    serve_write(18'h1F000, 4'b1111, 32'h12345678, 3);
    @(negedge clk);
    bus.M_MemRead = 1; bus.M_ALU_result = 32'h1F000;
    serve_read(18'h1F000);
    check("lw1f_dm", bus.M_DM_data, memf(18'h1F000));
    check("lw1f_miss", {16'd0, bus.miss_cnt}, 32'd2);
    check("hit_cnt4", {16'd0, bus.hit_cnt}, 32'd4);
    @(negedge clk);
    bus.M_MemRead = 0;
    rst = 1'b1;
    #1;
    check("rst2_hit", {16'd0, bus.hit_cnt}, 32'd0);
    check("rst2_miss", {16'd0, bus.miss_cnt}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    bus.M_MemRead = 1; bus.M_ALU_result = 32'h40;
    serve_read(18'h40);
    @(negedge clk);
    bus.M_ALU_result = 32'h140;
    serve_read(18'h140);
    check("lw140_dm", bus.M_DM_data, memf(18'h140));
    @(negedge clk);
    bus.M_ALU_result = 32'h40;
    serve_read(18'h40);
    check("reload40_dm", bus.M_DM_data, memf(18'h40));
    check("conflict_miss", {16'd0, bus.miss_cnt}, 32'd3);
    @(negedge clk);
    bus.M_ALU_result = 32'h80;
    #1;
    check("lw80_stall", {31'd0, bus.M_stall}, 32'd1);
    @(negedge clk);
    bus.mem_rdata = memf(18'h80); bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_rdata = memf(18'h84);
    @(negedge clk);
    bus.mem_ready = 0;
    #1;
    check("beat2_req", {31'd0, bus.mem_req}, 32'd1);
    check("beat2_addr", {14'd0, bus.mem_addr}, 32'h88);
    rst = 1'b1;
    #1;
    check("abort_req", {31'd0, bus.mem_req}, 32'd0);
    check("abort_stall", {31'd0, bus.M_stall}, 32'd0);
    rst = 1'b0;
    serve_read(18'h80);
    check("lw80_dm", bus.M_DM_data, memf(18'h80));
    check("lw80_miss", {16'd0, bus.miss_cnt}, 32'd1);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
